// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - bus-attached ALU with iterative multiply and bit-serial shifts
//
// Purpose: operand registers A/B loaded from a shared tri-state bus, a registered
// result with carry/zero flags, single-cycle ADD/SUB/AND/OR/XOR and multi-cycle
// MUL (shift-and-add) and SHL/SHR (one bit per cycle).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   bus                          shared tri-state data bus (WIDTH bits)
//   load_A, load_B               capture bus into A / B at the clock edge
//   write_A, write_B, write_ALU  drive A / B / result onto the bus
//   op                           0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 SHL, 7 SHR
//   start                        begin an operation (sampled only in IDLE)
//   busy, done                   iterative op in flight / one-cycle completion pulse
//   carry, zero                  registered flags

module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             load_A,
    input  logic             load_B,
    input  logic             write_A,
    input  logic             write_B,
    input  logic             write_ALU,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;

    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [WIDTH-1:0]   sh_q, sh_d, mplier_q, mplier_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [SW-1:0]      cnt_q, cnt_d, n_q, n_d;
    logic [1:0]         state_q, state_d;
    logic               carry_q, carry_d, zero_q, zero_d;
    logic               done_q, done_d, hold_q, hold_d, dir_q, dir_d;

    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   sh_nx;
    logic               sh_out;
    logic               upd;

    assign bus = write_A   ? a_q :
                 write_B   ? b_q :
                 write_ALU ? res_q : {WIDTH{1'bz}};

    assign sum    = {1'b0, a_q} + {1'b0, b_q};
    // Two's-complement subtract: carry out of A + ~B + 1 means "no borrow".
    assign diff   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    assign acc_nx = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    // dir_q = 1 is a right shift (SHR is op 7, SHL op 6, so op[0] picks direction).
    assign sh_out = dir_q ? sh_q[0] : sh_q[WIDTH-1];
    assign sh_nx  = dir_q ? (sh_q >> 1) : (sh_q << 1);

    always_comb begin
        a_d      = load_A ? bus : a_q;
        b_d      = load_B ? bus : b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        hold_d   = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        sh_d     = sh_q;
        dir_d    = dir_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        upd      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // hold_q blocks start during the done cycle of an iterative op.
                if (start && !hold_q) begin
                    case (op)
                        OP_ADD: begin res_d = sum[WIDTH-1:0];  carry_d = sum[WIDTH];  upd = 1'b1; end
                        OP_SUB: begin res_d = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; upd = 1'b1; end
                        OP_AND: begin res_d = a_q & b_q; carry_d = 1'b0; upd = 1'b1; end
                        OP_OR:  begin res_d = a_q | b_q; carry_d = 1'b0; upd = 1'b1; end
                        OP_XOR: begin res_d = a_q ^ b_q; carry_d = 1'b0; upd = 1'b1; end
                        OP_MUL: begin
                            state_d  = S_MUL;
                            cnt_d    = '0;
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, a_q};
                            mplier_d = b_q;
                        end
                        default: begin
                            if (b_q[SW-1:0] == '0) begin
                                res_d   = a_q;
                                carry_d = 1'b0;
                                upd     = 1'b1;
                            end else begin
                                state_d = S_SHIFT;
                                cnt_d   = '0;
                                n_d     = b_q[SW-1:0];
                                sh_d    = a_q;
                                dir_d   = op[0];
                            end
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    res_d   = acc_nx[WIDTH-1:0];
                    carry_d = |acc_nx[2*WIDTH-1:WIDTH];
                    upd     = 1'b1;
                    hold_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                sh_d  = sh_nx;
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == n_q - SW'(1)) begin
                    state_d = S_IDLE;
                    res_d   = sh_nx;
                    carry_d = sh_out;
                    upd     = 1'b1;
                    hold_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flags only move on completion; reset leaves zero = 0 even though result = 0.
        if (upd) begin
            zero_d = (res_d == '0);
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            hold_q   <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            sh_q     <= '0;
            dir_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            hold_q   <= hold_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            sh_q     <= sh_d;
            dir_q    <= dir_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu

module tb_multicycle_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    wire  [W-1:0] bus;
    logic [W-1:0] drv_val;
    logic         drv_en;
    logic         load_A, load_B, write_A, write_B, write_ALU, start;
    logic [2:0]   op;
    logic         busy, done, carry, zero;

    assign bus = drv_en ? drv_val : {W{1'bz}};

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .load_A(load_A), .load_B(load_B),
        .write_A(write_A), .write_B(write_B), .write_ALU(write_ALU),
        .op(op), .start(start),
        .busy(busy), .done(done), .carry(carry), .zero(zero)
    );

    always @(posedge clk) begin
        if (!rst)
            assert ($countones({write_A, write_B, write_ALU}) <= 1)
                else $error("FAIL bus_conflict: more than one write_* high");
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        int         cyc;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        int         cyc;
    } exp_t;

    vec_t vecs[14];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input bit to_b, input logic [7:0] v);
        drv_en  = 1'b1;
        drv_val = v;
        if (to_b) load_B = 1'b1; else load_A = 1'b1;
        tick();
        load_A = 1'b0;
        load_B = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] o, input logic [7:0] r, input logic c,
                            input logic z, input int cyc);
        exp_t e;
        e.res = r; e.c = c; e.z = z; e.cyc = cyc;
        sbq.push_back(e);
        op    = o;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for done counting busy cycles (n0 already elapsed), then check against the
    // scoreboard. With poke set, a start is raised in the done cycle and must be ignored.
    task automatic wait_done(input string nm, input int n0, input bit poke);
        int   n = n0;
        exp_t e;
        for (int k = 0; k < 40 && !done; k++) begin
            if (busy) n++;
            tick();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: done=0 required 1", nm);
            return;
        end
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s_scoreboard: done seen with queue empty", nm);
            return;
        end
        e = sbq.pop_front();
        check({nm, "_busy_cycles"}, n, e.cyc);
        check({nm, "_busy_at_done"}, busy, 0);
        check({nm, "_carry"}, carry, e.c);
        check({nm, "_zero"}, zero, e.z);
        write_ALU = 1'b1;
        #1;
        check({nm, "_result"}, bus, e.res);
        write_ALU = 1'b0;
        if (poke) begin
            op    = 3'd0;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        check({nm, "_done_pulse"}, done, 0);
        if (poke) begin
            check({nm, "_ignored_busy"}, busy, 0);
            write_ALU = 1'b1;
            #1;
            check({nm, "_ignored_result"}, bus, e.res);
            write_ALU = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] last_res;
        bit         saw_done;

        vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 0};
        vecs[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 0};
        vecs[2]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 0};
        vecs[3]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0};
        vecs[4]  = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 0};
        vecs[5]  = '{3'd4, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 0};
        vecs[6]  = '{3'd5, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 8};
        vecs[7]  = '{3'd5, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 8};
        vecs[8]  = '{3'd6, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 3};
        vecs[9]  = '{3'd7, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1};
        vecs[10] = '{3'd6, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 0};
        vecs[11] = '{3'd7, 8'h01, 8'h0F, 8'h00, 1'b0, 1'b1, 7};
        vecs[12] = '{3'd5, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 8};
        vecs[13] = '{3'd6, 8'hFF, 8'h07, 8'h80, 1'b1, 1'b0, 7};

        rst = 1'b1; drv_en = 1'b0; drv_val = '0;
        load_A = 0; load_B = 0; write_A = 0; write_B = 0; write_ALU = 0;
        start = 0; op = 3'd0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 0);
        write_ALU = 1'b1; #1; check("rst_result_bus", bus, 8'h00); write_ALU = 1'b0;
        write_A = 1'b1; #1; check("rst_a_bus", bus, 8'h00); write_A = 1'b0;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            load_reg(1'b0, vecs[i].a);
            load_reg(1'b1, vecs[i].b);
            start_op(vecs[i].op, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].cyc);
            wait_done($sformatf("vec%0d", i), 0, 1'b0);
        end
        last_res = vecs[13].res;

        // MUL with load_A and a second start during busy, start again in the done cycle
        load_reg(1'b0, 8'h03);
        load_reg(1'b1, 8'h05);
        start_op(3'd5, 8'h0F, 1'b0, 1'b0, 8);
        drv_en = 1'b1; drv_val = 8'h55; load_A = 1'b1;
        tick();
        load_A = 1'b0; drv_en = 1'b0;
        write_ALU = 1'b1; #1; check("busy_result_bus", bus, last_res); write_ALU = 1'b0;
        tick();
        op = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("mul_interfere", 3, 1'b1);
        write_A = 1'b1; #1; check("a_loaded_during_busy", bus, 8'h55); write_A = 1'b0;
        tick();

        // Set flags nonzero, then reset in the middle of a MUL
        load_reg(1'b0, 8'hFF);
        load_reg(1'b1, 8'h01);
        start_op(3'd0, 8'h00, 1'b1, 1'b1, 0);
        wait_done("add_wrap", 0, 1'b0);
        load_reg(1'b0, 8'h07);
        load_reg(1'b1, 8'h09);
        start_op(3'd5, 8'h3F, 1'b0, 1'b0, 8);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sbq.delete();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_carry", carry, 0);
        check("midrst_zero", zero, 0);
        write_ALU = 1'b1; #1; check("midrst_result_bus", bus, 8'h00); write_ALU = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("midrst_no_done", saw_done, 0);
        load_reg(1'b0, 8'h01);
        load_reg(1'b1, 8'h02);
        start_op(3'd0, 8'h03, 1'b0, 1'b0, 0);
        wait_done("add_after_rst", 0, 1'b0);

        // Register transfers and released bus
        load_reg(1'b0, 8'h77);
        write_A = 1'b1; load_B = 1'b1;
        tick();
        write_A = 1'b0; load_B = 1'b0;
        write_B = 1'b1; #1; check("copy_a_to_b", bus, 8'h77); write_B = 1'b0;
        write_A = 1'b1; load_A = 1'b1;
        tick();
        load_A = 1'b0;
        #1; check("a_hold_self_load", bus, 8'h77);
        write_A = 1'b0;
        drv_en = 1'b1; drv_val = 8'h5A;
        #1; check("bus_released", bus, 8'h5A);
        drv_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
